i2c_byte_master: RTL and testbench

Byte-level I2C master that generates the SCL/SDA waveform feeding the `i2c_extender` fan-out stage. Its `scl_o`/`sda_o` outputs drive the extender's SCL and SDA inputs. It accepts START, WRITE, READ and STOP commands over a valid/ready handshake and sequences each one as open-drain bit phases. It returns read data and ACK status with a one-cycle `done` pulse.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_quarter_tick.sv | 43 ++++
 rtl/i2c_byte_master.sv | 229 ++++++++++++++++++++++
 tb/tb_i2c_byte_master.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the byte-level I2C master: command codes, FSM states
// and bit-phase constants.
package i2c_pkg;

  localparam logic [1:0] CMD_START = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_STOP  = 2'd3;

  localparam int QUARTERS_PER_BIT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_ACK,
    ST_STOP
  } state_e;

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period prescaler: pulses tick once every CLK_DIV enabled cycles.
// A clear realigns the phase so the first quarter starts right after it.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("i2c_quarter_tick: CLK_DIV must be at least 1");
    end
  endgenerate

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/i2c_byte_master.sv
// Byte-level I2C master: sequences START/WRITE/READ/STOP commands into
// open-drain SCL/SDA quarter phases with registered, glitch-free line outputs.
module i2c_byte_master
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] wr_data,
  input  logic       mack,
  output logic [7:0] rd_data,
  output logic       sack,
  output logic       done,
  output logic       err,
  output logic       busy,
  output logic       bus_active,
  output logic       scl_o,
  output logic       sda_o,
  input  logic       sda_i
);

  localparam logic [1:0] Q_LAST   = 2'(QUARTERS_PER_BIT - 1);
  localparam logic [1:0] Q_SAMPLE = 2'd1;

  state_e     state_q, state_d;
  logic [1:0] quarter_q, quarter_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] cmd_q, cmd_d;
  logic       mack_q, mack_d;
  logic       ack_smp_q, ack_smp_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       sack_q, sack_d;
  logic       bus_active_q, bus_active_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       scl_q, scl_d;
  logic       sda_q, sda_d;

  logic busy_w;
  logic accept;
  logic tick;
  logic last_q;

  assign busy_w = (state_q != ST_IDLE);
  assign accept = cmd_valid && !busy_w;
  assign last_q = (quarter_q == Q_LAST);

  i2c_quarter_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (busy_w),
    .tick (tick)
  );

  always_comb begin
    state_d      = state_q;
    quarter_d    = quarter_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    cmd_d        = cmd_q;
    mack_d       = mack_q;
    ack_smp_d    = ack_smp_q;
    rd_data_d    = rd_data_q;
    sack_d       = sack_q;
    bus_active_d = bus_active_q;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cmd_d     = cmd;
          shift_d   = wr_data;
          mack_d    = mack;
          quarter_d = '0;
          bit_d     = '0;
          if (cmd == CMD_START) begin
            state_d = ST_START;
          end else if (!bus_active_q) begin
            // Data or STOP outside a transaction: reject without touching the bus.
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (cmd == CMD_STOP) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_START, ST_STOP: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (last_q) begin
            state_d      = ST_IDLE;
            done_d       = 1'b1;
            bus_active_d = (state_q == ST_START);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == Q_SAMPLE && cmd_q == CMD_READ) begin
            shift_d = {shift_q[6:0], sda_i};
          end
          if (last_q) begin
            if (cmd_q == CMD_WRITE) begin
              shift_d = {shift_q[6:0], 1'b0};
            end
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd7) begin
              state_d = ST_ACK;
            end
          end
        end
      end
      ST_ACK: begin
        if (tick) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == Q_SAMPLE) begin
            ack_smp_d = sda_i;
          end
          if (last_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            if (cmd_q == CMD_WRITE) begin
              sack_d = ack_smp_q;
            end else begin
              rd_data_d = shift_q;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Lines are decoded from the next phase so the flops present the new quarter on its first cycle.
    scl_d = 1'b1;
    sda_d = 1'b1;
    case (state_d)
      ST_IDLE: begin
        if (bus_active_d) begin
          scl_d = 1'b0;
          sda_d = sda_q;
        end
      end
      ST_START: begin
        case (quarter_d)
          2'd0:    begin scl_d = ~bus_active_d; sda_d = 1'b1; end
          2'd1:    begin scl_d = 1'b1;          sda_d = 1'b1; end
          2'd2:    begin scl_d = 1'b1;          sda_d = 1'b0; end
          default: begin scl_d = 1'b0;          sda_d = 1'b0; end
        endcase
      end
      ST_STOP: begin
        case (quarter_d)
          2'd0:    begin scl_d = 1'b0; sda_d = 1'b0; end
          2'd1:    begin scl_d = 1'b1; sda_d = 1'b0; end
          default: begin scl_d = 1'b1; sda_d = 1'b1; end
        endcase
      end
      ST_DATA: begin
        scl_d = (quarter_d == 2'd1) || (quarter_d == 2'd2);
        sda_d = (cmd_d == CMD_WRITE) ? shift_d[7] : 1'b1;
      end
      ST_ACK: begin
        scl_d = (quarter_d == 2'd1) || (quarter_d == 2'd2);
        sda_d = (cmd_d == CMD_READ) ? mack_d : 1'b1;
      end
      default: begin
        scl_d = 1'b1;
        sda_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      quarter_q    <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      cmd_q        <= CMD_START;
      mack_q       <= 1'b1;
      ack_smp_q    <= 1'b0;
      rd_data_q    <= 8'h00;
      sack_q       <= 1'b0;
      bus_active_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      scl_q        <= 1'b1;
      sda_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      quarter_q    <= quarter_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      cmd_q        <= cmd_d;
      mack_q       <= mack_d;
      ack_smp_q    <= ack_smp_d;
      rd_data_q    <= rd_data_d;
      sack_q       <= sack_d;
      bus_active_q <= bus_active_d;
      done_q       <= done_d;
      err_q        <= err_d;
      scl_q        <= scl_d;
      sda_q        <= sda_d;
    end
  end

  assign busy       = busy_w;
  assign cmd_ready  = ~busy_w;
  assign rd_data    = rd_data_q;
  assign sack       = sack_q;
  assign done       = done_q;
  assign err        = err_q;
  assign bus_active = bus_active_q;
  assign scl_o      = scl_q;
  assign sda_o      = sda_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Randomized bench for i2c_byte_master: a bus monitor plus slave model, and a
// transaction-level model of bus state, read data and ACK status.
module tb_i2c_byte_master;
  import i2c_pkg::*;

  localparam int CD  = 4;
  localparam int LIM = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'd0;
  logic [7:0] wr_data = 8'h00;
  logic       mack = 1'b1;
  logic       cmd_ready, sack, done, err, busy, bus_active, scl_o, sda_o, sda_i;
  logic [7:0] rd_data;

  always #5 clk = ~clk;

  i2c_byte_master #(.CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .wr_data(wr_data), .mack(mack), .rd_data(rd_data), .sack(sack), .done(done),
    .err(err), .busy(busy), .bus_active(bus_active), .scl_o(scl_o), .sda_o(sda_o),
    .sda_i(sda_i)
  );

  // Slave: drives one bit per SCL-low window, counted by SCL falling edges.
  logic [1:0] slv_mode = CMD_START;
  logic [7:0] slv_tx = 8'hFF;
  logic       slv_ack = 1'b1;
  logic       slv_bit;
  int         idx = 0;
  assign slv_bit = (slv_mode == CMD_READ && idx < 8) ? slv_tx[3'(7 - idx)] :
                   (slv_mode == CMD_WRITE && idx == 8) ? slv_ack : 1'b1;
  assign sda_i = sda_o & slv_bit;

  // Bus monitor
  logic        mon_clr = 1'b0;
  logic        scl_p = 1'b1, sda_p = 1'b1;
  int          n_startc = 0, n_stopc = 0, n_rlow = 0, n_rise = 0, n_edges = 0;
  logic [15:0] rise_o = '0, rise_i = '0;

  always @(negedge clk) begin
    if (mon_clr) begin
      n_startc = 0; n_stopc = 0; n_rlow = 0; n_rise = 0; n_edges = 0;
      rise_o = '0; rise_i = '0; idx = 0;
    end else begin
      if (scl_p && scl_o && (sda_p != sda_o)) begin
        if (sda_o) n_stopc++;
        else n_startc++;
      end
      if (!scl_p && !scl_o && !sda_p && sda_o) n_rlow++;
      if (!scl_p && scl_o) begin
        n_rise++;
        rise_o = {rise_o[14:0], sda_o};
        rise_i = {rise_i[14:0], sda_i};
      end
      if (scl_p && !scl_o) idx++;
      if ((scl_p != scl_o) || (sda_p != sda_o)) n_edges++;
    end
    scl_p = scl_o;
    sda_p = sda_o;
  end

  // Transaction-level model
  logic       m_bus = 1'b0;
  logic       m_sda = 1'b1;
  logic [7:0] m_rd = 8'h00;
  logic       m_sack = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update(input logic [1:0] c, input logic mk, input logic [7:0] tx, input logic ak);
    case (c)
      CMD_START: begin m_bus = 1'b1; m_sda = 1'b0; end
      CMD_STOP:  begin m_bus = 1'b0; m_sda = 1'b1; end
      CMD_WRITE: begin m_sack = ak; m_sda = 1'b1; end
      default:   begin m_rd = tx; m_sda = mk; end
    endcase
  endtask

  task automatic start_cmd(input logic [1:0] c, input logic [7:0] d, input logic mk,
                           input logic [7:0] tx, input logic ak);
    slv_mode = c; slv_tx = tx; slv_ack = ak;
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    cmd_valid = 1'b1; cmd = c; wr_data = d; mack = mk;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wr_data = 8'($urandom);
  endtask

  task automatic finish_cmd(input logic [1:0] c, input logic [7:0] d, input logic mk,
                            input logic [7:0] tx, input logic ak);
    logic legal, is_data;
    int k, exp_rlow;
    legal    = (c == CMD_START) || m_bus;
    is_data  = (c == CMD_WRITE) || (c == CMD_READ);
    exp_rlow = (c == CMD_START && m_bus && !m_sda) ? 1 : 0;
    @(negedge clk);
    if (!legal) begin
      check("ill_done_err", {done, err}, 2'b11);
      check("ill_busy", busy, 1'b0);
      repeat (8 * CD) @(negedge clk);
      check("ill_no_bus", n_edges, 0);
      check("ill_lines", {scl_o, sda_o}, {~m_bus, m_bus ? m_sda : 1'b1});
      check("ill_rd", rd_data, m_rd);
      check("ill_sack", sack, m_sack);
      $display("[TB] cmd=%0d illegal rejected", c);
      return;
    end
    check("busy_rise", busy, 1'b1);
    k = 0;
    while (!done && k < LIM) begin
      @(negedge clk);
      k++;
    end
    check("duration", k, is_data ? 36 * CD : 4 * CD);
    check("err", err, 1'b0);
    check("ready_busy", {cmd_ready, busy}, 2'b10);
    model_update(c, mk, tx, ak);
    check("rd_data", rd_data, m_rd);
    check("sack", sack, m_sack);
    check("bus_active", bus_active, m_bus);
    check("idle_lines", {scl_o, sda_o}, {~m_bus, m_bus ? m_sda : 1'b1});
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("start_cond", n_startc, (c == CMD_START) ? 1 : 0);
    check("stop_cond", n_stopc, (c == CMD_STOP) ? 1 : 0);
    if (is_data) check("rises", n_rise, 9);
    if (c == CMD_WRITE) check("wr_bits", rise_o[8:0], {d, 1'b1});
    if (c == CMD_READ) begin
      check("rd_bits", rise_i[8:1], tx);
      check("rd_mack", rise_o[0], mk);
    end
    if (c == CMD_START) check("rstart_rise_low", n_rlow, exp_rlow);
    $display("[TB] cmd=%0d wr=%02h mack=%0d slv=%02h/%0d took %0d cycles", c, d, mk, tx, ak, k);
  endtask

  task automatic do_cmd(input logic [1:0] c, input logic [7:0] d, input logic mk,
                        input logic [7:0] tx, input logic ak);
    start_cmd(c, d, mk, tx, ak);
    finish_cmd(c, d, mk, tx, ak);
  endtask

  task automatic back_to_back();
    logic [1:0] seq [6];
    int k;
    seq = '{CMD_START, CMD_WRITE, CMD_READ, CMD_STOP, CMD_START, CMD_STOP};
    slv_tx = 8'hFF; slv_ack = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd = seq[0]; wr_data = 8'($urandom); mack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b2b_busy", busy, 1'b1);
      k = 0;
      while (!done && k < LIM) begin
        @(negedge clk);
        k++;
      end
      check("b2b_duration", k, (seq[i] == CMD_WRITE || seq[i] == CMD_READ) ? 36 * CD : 4 * CD);
      check("b2b_err", err, 1'b0);
      model_update(seq[i], 1'b1, 8'hFF, 1'b1);
      check("b2b_state", {bus_active, sack, rd_data}, {m_bus, m_sack, m_rd});
      $display("[TB] b2b cmd=%0d done after %0d cycles", seq[i], k);
      if (i < 5) cmd = seq[i+1];
      else cmd_valid = 1'b0;
    end
    k = 0;
    repeat (12 * CD) begin
      @(negedge clk);
      if (done || busy) k++;
    end
    check("b2b_no_extra", k, 0);
  endtask

  task automatic reset_mid_write();
    int k;
    do_cmd(CMD_START, 8'h00, 1'b1, 8'hFF, 1'b1);
    start_cmd(CMD_WRITE, 8'h96, 1'b1, 8'hFF, 1'b0);
    @(negedge clk);
    repeat (4 * 4 * CD) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_lines", {scl_o, sda_o}, 2'b11);
    check("rst_busy_bus", {busy, bus_active, done}, 3'b000);
    m_bus = 1'b0; m_sda = 1'b1; m_rd = 8'h00; m_sack = 1'b0;
    k = 0;
    repeat (40 * CD) begin
      @(negedge clk);
      if (done || busy) k++;
    end
    check("rst_no_done", k, 0);
    check("rst_rd_sack", {rd_data, sack}, {m_rd, m_sack});
    $display("[TB] reset during WRITE bit 4");
  endtask

  initial begin
    logic [1:0] c;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check("rst_outputs", {scl_o, sda_o, cmd_ready, busy, done, err, bus_active, sack},
          8'b1110_0000);
    check("rst_rd_data", rd_data, 8'h00);

    do_cmd(CMD_WRITE, 8'h5A, 1'b1, 8'hFF, 1'b0);
    do_cmd(CMD_START, 8'h00, 1'b1, 8'hFF, 1'b1);
    do_cmd(CMD_WRITE, 8'hA5, 1'b1, 8'hFF, 1'b0);
    do_cmd(CMD_READ, 8'h00, 1'b1, 8'h3C, 1'b1);
    do_cmd(CMD_START, 8'h00, 1'b1, 8'hFF, 1'b1);
    do_cmd(CMD_START, 8'h00, 1'b1, 8'hFF, 1'b1);
    do_cmd(CMD_STOP, 8'h00, 1'b1, 8'hFF, 1'b1);

    for (int i = 0; i < 30; i++) begin
      c = 2'($urandom_range(0, 3));
      do_cmd(c, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
    end
    do_cmd(CMD_STOP, 8'h00, 1'b1, 8'hFF, 1'b1);

    back_to_back();
    reset_mid_write();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
